fir_operand_seq: RTL and testbench

FIR_OPERAND_SEQ -- requirements
Module: fir_operand_seq

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_operand_seq_if.sv | 43 ++++
 rtl/fir_delay_line.sv | 30 +++
 rtl/fir_operand_seq.sv | 102 ++++++++++
 tb/tb_fir_operand_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and types for the FIR operand sequencer
package fir_pkg;

  localparam int NTAPS = 64;
  localparam int DW    = 16;
  localparam int AW    = $clog2(NTAPS);

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_MUL = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fir_operand_seq_if.sv
// rtl/fir_operand_seq_if.sv - sample, coefficient and operand-pair bus of the sequencer
interface fir_operand_seq_if #(
  parameter int DW = fir_pkg::DW,
  parameter int AW = fir_pkg::AW
);

  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [DW-1:0] coef_data;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [1:0]    op_select;
  logic          op_first;
  logic          op_last;

  logic          busy;

  modport master (
    output coef_we, coef_addr, coef_data,
    output in_valid, in_data,
    input  in_ready,
    input  op_valid, op_a, op_b, op_select, op_first, op_last,
    output op_ready,
    input  busy
  );

  modport slave (
    input  coef_we, coef_addr, coef_data,
    input  in_valid, in_data,
    output in_ready,
    output op_valid, op_a, op_b, op_select, op_first, op_last,
    input  op_ready,
    output busy
  );

endinterface

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - circular sample buffer with one write port and one indexed read
module fir_delay_line #(
  parameter int NTAPS = fir_pkg::NTAPS,
  parameter int DW    = fir_pkg::DW,
  parameter int AW    = fir_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [NTAPS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_operand_seq.sv
// rtl/fir_operand_seq.sv - walks all taps for each accepted sample, presenting
// (x[n-k], c[k]) multiply pairs to a downstream ALU with a valid/ready handshake.
module fir_operand_seq
  import fir_pkg::*;
#(
  parameter int NTAPS = fir_pkg::NTAPS,
  parameter int DW    = fir_pkg::DW,
  parameter int AW    = fir_pkg::AW
) (
  input logic               clk,
  input logic               rst,
  fir_operand_seq_if.slave  bus
);

  state_t        state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] k;
  logic [DW-1:0] coef [NTAPS];

  logic          accept;
  logic          handshake;
  logic          k_last;
  logic          run;
  logic [AW:0]   diff;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;

  assign run       = (state == ST_RUN);
  assign accept    = (state == ST_IDLE) && bus.in_valid;
  assign handshake = run && bus.op_ready;
  assign k_last    = (k == AW'(NTAPS - 1));

  // One extra bit on the subtraction exposes the borrow, so the wrap also
  // holds for tap counts that are not a power of two.
  assign diff  = {1'b0, wptr} - {1'b0, k};
  assign raddr = diff[AW] ? AW'(diff + (AW+1)'(NTAPS)) : diff[AW-1:0];

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW),
    .AW    (AW)
  ) u_delay (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (wptr),
    .wdata (bus.in_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Coefficients only change between samples; a write in the accept cycle
  // lands before the first pair is read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef[i] <= '0;
      end
    end else if ((state == ST_IDLE) && bus.coef_we) begin
      coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      wptr  <= '0;
      k     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            k     <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (handshake) begin
            if (k_last) begin
              k     <= '0;
              state <= ST_IDLE;
              wptr  <= (wptr == AW'(NTAPS - 1)) ? '0 : wptr + 1'b1;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = run;
  assign bus.op_valid  = run;
  assign bus.op_select = run ? SEL_MUL : SEL_ADD;
  assign bus.op_first  = run && (k == '0);
  assign bus.op_last   = run && k_last;
  assign bus.op_a      = run ? rdata : '0;
  assign bus.op_b      = run ? coef[k] : '0;

endmodule

// File: tb/tb_fir_operand_seq.sv
// tb/tb_fir_operand_seq.sv - scoreboard bench for fir_operand_seq
module tb_fir_operand_seq;

  localparam int NT = 64;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        first;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;

  fir_operand_seq_if #(.DW(16), .AW(6)) dif ();

  fir_operand_seq #(.NTAPS(NT), .DW(16), .AW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  exp_t        exp_q [$];
  logic [15:0] hist  [$];
  logic [15:0] coef_m [NT];
  int          n_checks = 0;
  int          n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: pops one expected pair per handshake.
  always @(negedge clk) begin
    if (rst && dif.op_valid && dif.op_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_op_valid", 64'(dif.op_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("op_pair", {dif.op_a, dif.op_b, dif.op_first, dif.op_last, dif.op_select},
            {e.a, e.b, e.first, e.last, 2'b01});
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load_coefs();
    for (int i = 0; i < NT; i++) begin
      dif.coef_we   = 1'b1;
      dif.coef_addr = 6'(i);
      dif.coef_data = 16'(i + 1);
      coef_m[i]     = 16'(i + 1);
      @(posedge clk); #1;
    end
    dif.coef_we = 1'b0;
  endtask

  task automatic send(input logic [15:0] v, input bit do_w,
                      input logic [5:0] wa, input logic [15:0] wd);
    int t;
    t = 0;
    while (!dif.in_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (!dif.in_ready) chk("in_ready_timeout", 64'(dif.in_ready), 64'd1);
    dif.in_valid = 1'b1;
    dif.in_data  = v;
    if (do_w) begin
      dif.coef_we   = 1'b1;
      dif.coef_addr = wa;
      dif.coef_data = wd;
      coef_m[wa]    = wd;
    end
    hist.push_back(v);
    for (int kk = 0; kk < NT; kk++) begin
      exp_t e;
      e.a     = (kk < hist.size()) ? hist[hist.size() - 1 - kk] : 16'd0;
      e.b     = coef_m[kk];
      e.first = (kk == 0);
      e.last  = (kk == NT - 1);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    dif.coef_we  = 1'b0;
    chk("first_op_latency", {63'd0, dif.op_valid & dif.op_first}, 64'd1);
  endtask

  task automatic wait_done(input int expect_cycles);
    int cnt;
    cnt = 0;
    while (!dif.in_ready && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (expect_cycles >= 0) chk("sample_occupancy", 64'(cnt), 64'(expect_cycles));
    else if (!dif.in_ready) chk("done_timeout", 64'(dif.in_ready), 64'd1);
  endtask

  initial begin
    rst           = 1'b0;
    dif.coef_we   = 1'b0;
    dif.coef_addr = '0;
    dif.coef_data = '0;
    dif.in_valid  = 1'b0;
    dif.in_data   = '0;
    dif.op_ready  = 1'b1;
    for (int i = 0; i < NT; i++) coef_m[i] = 16'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(dif.in_ready),  64'd1);
    chk("rst_op_valid",  64'(dif.op_valid),  64'd0);
    chk("rst_op_select", 64'(dif.op_select), 64'd0);
    chk("rst_busy",      64'(dif.busy),      64'd0);
    chk("rst_op_ab",     {32'd0, dif.op_a, dif.op_b}, 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    load_coefs();
    send(16'd100, 1'b0, 6'd0, 16'd0);
    wait_done(NT);

    // Stall at k=10 for five edges
    send(16'd200, 1'b0, 6'd0, 16'd0);
    repeat (10) @(posedge clk);
    #1;
    dif.op_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_frozen", {dif.op_valid, dif.op_a, dif.op_b, dif.op_first, dif.op_last},
          {1'b1, exp_q[0].a, exp_q[0].b, exp_q[0].first, exp_q[0].last});
    end
    @(posedge clk); #1;
    dif.op_ready = 1'b1;
    wait_done(-1);

    // Coefficient write while running must be ignored
    send(16'd300, 1'b0, 6'd0, 16'd0);
    repeat (5) @(posedge clk);
    #1;
    dif.coef_we   = 1'b1;
    dif.coef_addr = 6'd0;
    dif.coef_data = 16'd999;
    @(posedge clk); #1;
    dif.coef_we = 1'b0;
    wait_done(-1);

    // Write in the accept cycle is used by that sample
    send(16'hFFFB, 1'b1, 6'd5, 16'hFFF9);
    wait_done(NT);

    // Reset in the middle of a run
    send(16'd400, 1'b0, 6'd0, 16'd0);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrun_op_valid",  64'(dif.op_valid),  64'd0);
    chk("midrun_in_ready",  64'(dif.in_ready),  64'd1);
    chk("midrun_busy",      64'(dif.busy),      64'd0);
    chk("midrun_op_select", 64'(dif.op_select), 64'd0);
    chk("midrun_op_ab",     {32'd0, dif.op_a, dif.op_b}, 64'd0);
    exp_q.delete();
    hist.delete();
    for (int i = 0; i < NT; i++) coef_m[i] = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_restart", 64'(dif.op_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Fresh delay line: samples 1..70, covering early zeros and pointer wrap
    load_coefs();
    for (int i = 1; i <= 70; i++) begin
      send(16'(i), 1'b0, 6'd0, 16'd0);
      wait_done(NT);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
